// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Module   : core_pkg
// Brief    : Shared RV32I core types and constants (fetch FSM, instr fields).
// Revision : 1.0
// ============================================================================
package core_pkg;

    localparam logic [31:0] c_reset_pc = 32'h0000_0000;

    typedef enum logic [0:0] {
        ST_REQ  = 1'b0,
        ST_WAIT = 1'b1
    } fetch_state_t;

    // Instruction field positions, shared with the control decoder
    localparam int c_op_lsb = 0;
    localparam int c_op_msb = 6;
    localparam int c_f3_lsb = 12;
    localparam int c_f3_msb = 14;
    localparam int c_f7_lsb = 25;
    localparam int c_f7_msb = 31;

endpackage
`default_nettype wire

// File: rtl/if_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_unit_if
// Brief    : Fetch unit bus bundle: imem request/response, redirect, decode.
// Revision : 1.0
// ============================================================================
interface if_fetch_unit_if;

    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [6:0]  id_op;
    logic [2:0]  id_funct3;
    logic [6:0]  id_funct7;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_resp_valid, imem_resp_data,
        input  redirect_valid, redirect_pc,
        output id_valid, id_instr, id_pc, id_op, id_funct3, id_funct7,
        input  id_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_resp_valid, imem_resp_data,
        output redirect_valid, redirect_pc,
        input  id_valid, id_instr, id_pc, id_op, id_funct3, id_funct7,
        output id_ready
    );

endinterface
`default_nettype wire

// File: rtl/if_fifo.sv
`default_nettype none
// ============================================================================
// Module   : if_fifo
// Brief    : Synchronous fetch buffer FIFO with flush; head read from storage.
// Revision : 1.0
// ============================================================================
module if_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  wire logic                   clk,
    input  wire logic                   rstn,
    input  wire logic                   i_push,
    input  wire logic [WIDTH-1:0]       i_push_data,
    input  wire logic                   i_pop,
    input  wire logic                   i_flush,
    output logic [WIDTH-1:0]            o_head_data,
    output logic [$clog2(DEPTH):0]      o_count,
    output logic                        o_full,
    output logic                        o_empty
);

    localparam int c_aw = $clog2(DEPTH);
    localparam int c_cw = c_aw + 1;
    localparam logic [c_cw-1:0] c_depth = c_cw'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_cw-1:0]  r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full      = (r_count == c_depth);
    assign o_empty     = (r_count == '0);
    assign o_count     = r_count;
    assign o_head_data = r_mem[r_rd_ptr];
    assign w_do_push   = i_push & ~o_full;
    assign w_do_pop    = i_pop & ~o_empty;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + {{(c_cw-1){1'b0}}, w_do_push}
                               - {{(c_cw-1){1'b0}}, w_do_pop};
        end
    end

endmodule
`default_nettype wire

// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_unit
// Brief    : RV32I instruction fetch front end with redirect and fetch buffer.
// Revision : 1.0
// ============================================================================
module if_fetch_unit
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = c_reset_pc,
    parameter int          FIFO_DEPTH = 2
) (
    input  wire logic       clk,
    input  wire logic       rstn,
    if_fetch_unit_if.master bus
);

    localparam int c_cw = $clog2(FIFO_DEPTH) + 1;
    localparam logic [c_cw-1:0] c_depth = c_cw'(FIFO_DEPTH);

    fetch_state_t    r_state;
    logic [31:0]     r_fetch_pc;
    logic [31:0]     r_req_pc;
    logic            r_req_valid;
    logic            r_discard;

    logic            w_redirect;
    logic            w_req_fire;
    logic            w_push;
    logic            w_pop;
    logic            w_space_next;
    logic            w_fifo_full;
    logic            w_fifo_empty;
    logic [c_cw-1:0] w_count;
    logic [c_cw-1:0] w_count_next;
    logic [31:0]     w_target;
    logic [63:0]     w_head;

    assign w_redirect   = bus.redirect_valid;
    assign w_target     = bus.redirect_pc & ~32'h3;
    assign w_req_fire   = r_req_valid & bus.imem_req_ready;
    // Wrong-path responses and anything arriving alongside a redirect are dropped
    assign w_push       = (r_state == ST_WAIT) & bus.imem_resp_valid & ~r_discard
                          & ~w_redirect & ~w_fifo_full;
    assign w_pop        = ~w_fifo_empty & bus.id_ready & ~w_redirect;
    assign w_count_next = w_count + {{(c_cw-1){1'b0}}, w_push}
                                  - {{(c_cw-1){1'b0}}, w_pop};
    assign w_space_next = (w_count_next < c_depth);

    if_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (64)
    ) u_fifo (
        .clk         (clk),
        .rstn        (rstn),
        .i_push      (w_push),
        .i_push_data ({r_req_pc, bus.imem_resp_data}),
        .i_pop       (w_pop),
        .i_flush     (w_redirect),
        .o_head_data (w_head),
        .o_count     (w_count),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state     <= ST_REQ;
            r_fetch_pc  <= RESET_PC;
            r_req_pc    <= RESET_PC;
            r_req_valid <= 1'b0;
            r_discard   <= 1'b0;
        end else if (w_redirect) begin
            r_fetch_pc <= w_target;
            if (r_state == ST_REQ) begin
                if (w_req_fire) begin
                    r_state     <= ST_WAIT;
                    r_req_pc    <= r_fetch_pc;
                    r_req_valid <= 1'b0;
                    r_discard   <= 1'b1;
                end else begin
                    // FIFO is flushed this edge, so there is always room
                    r_req_valid <= 1'b1;
                end
            end else if (bus.imem_resp_valid) begin
                r_state     <= ST_REQ;
                r_req_valid <= 1'b1;
                r_discard   <= 1'b0;
            end else begin
                r_discard <= 1'b1;
            end
        end else if (r_state == ST_REQ) begin
            if (w_req_fire) begin
                r_state     <= ST_WAIT;
                r_req_pc    <= r_fetch_pc;
                r_fetch_pc  <= r_fetch_pc + 32'd4;
                r_req_valid <= 1'b0;
            end else begin
                r_req_valid <= w_space_next;
            end
        end else if (bus.imem_resp_valid) begin
            r_state     <= ST_REQ;
            r_discard   <= 1'b0;
            r_req_valid <= w_space_next;
        end
    end

    assign bus.imem_req_valid = r_req_valid;
    assign bus.imem_req_addr  = r_fetch_pc;
    assign bus.id_valid       = ~w_fifo_empty;
    assign bus.id_instr       = w_head[31:0];
    assign bus.id_pc          = w_head[63:32];
    assign bus.id_op          = w_head[c_op_msb:c_op_lsb];
    assign bus.id_funct3      = w_head[c_f3_msb:c_f3_lsb];
    assign bus.id_funct7      = w_head[c_f7_msb:c_f7_lsb];

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_fetch_unit
// Brief    : Directed self-checking bench for if_fetch_unit with a memory model.
// Revision : 1.0
// ============================================================================
module tb_if_fetch_unit;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    if_fetch_unit_if bus ();

    if_fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int tests = 0;
    int fails = 0;

    // Instruction memory: one in-order response mem_lat cycles after accept, data = 0x13 + addr
    int          mem_lat  = 1;
    logic        mem_pend = 1'b0;
    int          mem_cnt  = 0;
    logic [31:0] mem_addr = 32'h0;

    always @(posedge clk) begin
        if (!rstn) begin
            mem_pend <= 1'b0;
        end else begin
            if (mem_pend) begin
                if (mem_cnt == 0) mem_pend <= 1'b0;
                else              mem_cnt  <= mem_cnt - 1;
            end
            if (bus.imem_req_valid && bus.imem_req_ready) begin
                mem_pend <= 1'b1;
                mem_cnt  <= mem_lat - 1;
                mem_addr <= bus.imem_req_addr;
            end
        end
    end

    assign bus.imem_resp_valid = mem_pend && (mem_cnt == 0);
    assign bus.imem_resp_data  = mem_addr + 32'h13;

    logic [31:0] reqs[$];
    logic [31:0] pop_pc[$];
    logic [31:0] pop_instr[$];

    always @(negedge clk) begin
        if (rstn) begin
            if (bus.imem_req_valid && bus.imem_req_ready) reqs.push_back(bus.imem_req_addr);
            if (bus.id_valid && bus.id_ready && !bus.redirect_valid) begin
                pop_pc.push_back(bus.id_pc);
                pop_instr.push_back(bus.id_instr);
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_logs();
        reqs.delete();
        pop_pc.delete();
        pop_instr.delete();
    endtask

    task automatic start(input int lat, input logic rdy);
        mem_lat                = lat;
        bus.id_ready           = rdy;
        bus.redirect_valid     = 1'b0;
        bus.imem_req_ready     = 1'b1;
        rstn                   = 1'b0;
        tick(2);
        rstn = 1'b1;
        clear_logs();
    endtask

    task automatic redirect(input logic [31:0] pc);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = pc;
        tick(1);
        bus.redirect_valid = 1'b0;
        clear_logs();
    endtask

    task automatic test_reset();
        bus.id_ready       = 1'b1;
        bus.imem_req_ready = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        rstn               = 1'b0;
        tick(3);
        tests++; if (bus.imem_req_valid !== 1'b0) begin fails++; $display("FAIL reset_req_valid: got %b want 0", bus.imem_req_valid); end
        tests++; if (bus.id_valid !== 1'b0) begin fails++; $display("FAIL reset_id_valid: got %b want 0", bus.id_valid); end
        tests++; if (bus.id_instr !== 32'h0 || bus.id_pc !== 32'h0) begin fails++; $display("FAIL reset_id_data: got instr %h pc %h want 0 0", bus.id_instr, bus.id_pc); end
    endtask

    task automatic test_streaming();
        mem_lat      = 1;
        bus.id_ready = 1'b1;
        rstn         = 1'b1;
        clear_logs();
        tick(1);
        tests++; if (bus.id_valid !== 1'b0 || bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h0) begin fails++; $display("FAIL stream_cycle1: got id_valid %b req_valid %b addr %h want 0 1 0", bus.id_valid, bus.imem_req_valid, bus.imem_req_addr); end
        tick(1);
        tests++; if (bus.id_valid !== 1'b0) begin fails++; $display("FAIL stream_cycle2: got id_valid %b want 0", bus.id_valid); end
        tick(1);
        tests++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h0 || bus.id_instr !== 32'h13) begin fails++; $display("FAIL stream_first: got valid %b pc %h instr %h want 1 0 13", bus.id_valid, bus.id_pc, bus.id_instr); end
        tests++; if (bus.id_op !== 7'h13 || bus.id_funct3 !== 3'h0 || bus.id_funct7 !== 7'h0) begin fails++; $display("FAIL stream_fields: got op %h f3 %h f7 %h want 13 0 0", bus.id_op, bus.id_funct3, bus.id_funct7); end
        tick(20);
        tests++; if (pop_pc.size() < 5) begin fails++; $display("FAIL stream_count: got %0d pops want >=5", pop_pc.size()); end
        for (int i = 0; i < 5 && i < pop_pc.size(); i++) begin
            tests++; if (pop_pc[i] !== 32'(4 * i) || pop_instr[i] !== 32'(4 * i + 32'h13)) begin fails++; $display("FAIL stream_order[%0d]: got pc %h instr %h want %h %h", i, pop_pc[i], pop_instr[i], 4 * i, 4 * i + 32'h13); end
        end
    endtask

    task automatic test_backpressure();
        int bad;
        start(1, 1'b0);
        tick(12);
        tests++; if (reqs.size() != 2 || reqs[0] !== 32'h0 || reqs[1] !== 32'h4) begin fails++; $display("FAIL bp_fetches: got %0d fetches want 2 (0,4)", reqs.size()); end
        tests++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h0) begin fails++; $display("FAIL bp_head: got valid %b pc %h want 1 0", bus.id_valid, bus.id_pc); end
        bad = 0;
        repeat (4) begin
            if (bus.imem_req_valid !== 1'b0) bad++;
            tick(1);
        end
        tests++; if (bad != 0) begin fails++; $display("FAIL bp_req_while_full: got %0d cycles with req_valid want 0", bad); end
        bus.id_ready = 1'b1;
        tick(12);
        tests++; if (pop_pc.size() < 3) begin fails++; $display("FAIL bp_release_count: got %0d pops want >=3", pop_pc.size()); end
        bad = 0;
        for (int i = 0; i < pop_pc.size(); i++) if (pop_pc[i] !== 32'(4 * i)) bad++;
        tests++; if (bad != 0) begin fails++; $display("FAIL bp_release_order: got %0d out-of-sequence pops want 0", bad); end
    endtask

    task automatic test_req_stall();
        bit found = 0;
        int bad   = 0;
        int n8    = 0;
        start(1, 1'b1);
        for (int i = 0; i < 20 && !found; i++) begin
            tick(1);
            if (bus.imem_req_valid === 1'b1 && bus.imem_req_addr === 32'h8) found = 1;
        end
        tests++; if (!found) begin fails++; $display("FAIL stall_reach_8: got no request at 8 want one within 20 cycles"); end
        bus.imem_req_ready = 1'b0;
        repeat (3) begin
            if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h8) bad++;
            tick(1);
        end
        bus.imem_req_ready = 1'b1;
        tests++; if (bad != 0) begin fails++; $display("FAIL stall_hold: got %0d unstable cycles want 0", bad); end
        tick(12);
        foreach (reqs[i]) if (reqs[i] === 32'h8) n8++;
        tests++; if (n8 != 1) begin fails++; $display("FAIL stall_single_fetch: got %0d fetches of 8 want 1", n8); end
        tests++; if (pop_pc.size() < 4 || pop_pc[2] !== 32'h8 || pop_pc[3] !== 32'hC) begin fails++; $display("FAIL stall_order: got pc2 %h pc3 %h want 8 c", pop_pc[2], pop_pc[3]); end
    endtask

    task automatic test_redirect_wait();
        bit found = 0;
        int bad   = 0;
        start(4, 1'b1);
        for (int i = 0; i < 40 && !found; i++) begin
            tick(1);
            if (reqs.size() > 0 && reqs[reqs.size() - 1] === 32'hC) found = 1;
        end
        tests++; if (!found) begin fails++; $display("FAIL rw_reach_c: got no fetch of c want one within 40 cycles"); end
        tests++; if (pop_pc.size() != 3 || pop_pc[2] !== 32'h8) begin fails++; $display("FAIL rw_pre: got %0d pops want 3 ending at 8", pop_pc.size()); end
        redirect(32'h100);
        tick(30);
        foreach (pop_pc[i]) if (pop_pc[i] === 32'hC) bad++;
        tests++; if (bad != 0) begin fails++; $display("FAIL rw_no_c: got %0d deliveries of c want 0", bad); end
        tests++; if (pop_pc.size() < 2 || pop_pc[0] !== 32'h100 || pop_instr[0] !== 32'h113 || pop_pc[1] !== 32'h104) begin fails++; $display("FAIL rw_target: got %h %h want 100 104", pop_pc[0], pop_pc[1]); end

        // response and redirect in the same cycle
        found = 0;
        start(4, 1'b1);
        for (int i = 0; i < 40 && !found; i++) begin
            tick(1);
            if (reqs.size() > 0 && reqs[reqs.size() - 1] === 32'hC) found = 1;
        end
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick(1);
            if (bus.imem_resp_valid === 1'b1) found = 1;
        end
        tests++; if (!found) begin fails++; $display("FAIL rw_resp_seen: got no response want one within 10 cycles"); end
        redirect(32'h200);
        tick(30);
        tests++; if (pop_pc.size() < 1 || pop_pc[0] !== 32'h200 || pop_instr[0] !== 32'h213) begin fails++; $display("FAIL rw_coincident: got pc %h instr %h want 200 213", pop_pc[0], pop_instr[0]); end
    endtask

    task automatic test_redirect_corners();
        bit found = 0;
        start(1, 1'b1);
        tick(6);
        redirect(32'hFFFF_FFFC);
        tick(12);
        tests++; if (reqs.size() < 2 || reqs[0] !== 32'hFFFF_FFFC || reqs[1] !== 32'h0) begin fails++; $display("FAIL rc_wrap_fetch: got %h %h want fffffffc 00000000", reqs[0], reqs[1]); end
        tests++; if (pop_pc.size() < 1 || pop_pc[0] !== 32'hFFFF_FFFC || pop_instr[0] !== 32'h0000_000F) begin fails++; $display("FAIL rc_wrap_deliver: got pc %h instr %h want fffffffc 0000000f", pop_pc[0], pop_instr[0]); end
        redirect(32'h0000_0103);
        tick(8);
        tests++; if (reqs.size() < 1 || reqs[0] !== 32'h100) begin fails++; $display("FAIL rc_align: got %h want 100", reqs[0]); end
        tests++; if (pop_pc.size() < 1 || pop_pc[0] !== 32'h100) begin fails++; $display("FAIL rc_align_pc: got %h want 100", pop_pc[0]); end
        redirect(32'hFE00_7000);
        for (int i = 0; i < 15 && !found; i++) begin
            tick(1);
            if (bus.id_valid === 1'b1) found = 1;
        end
        tests++; if (!found || bus.id_op !== 7'h13 || bus.id_funct3 !== 3'h7 || bus.id_funct7 !== 7'h7F) begin fails++; $display("FAIL rc_fields: got valid %b op %h f3 %h f7 %h want 1 13 7 7f", found, bus.id_op, bus.id_funct3, bus.id_funct7); end

        // redirect while decode pops a full buffer
        start(1, 1'b0);
        tick(12);
        tests++; if (bus.id_valid !== 1'b1) begin fails++; $display("FAIL rc_pop_pre: got id_valid %b want 1", bus.id_valid); end
        bus.id_ready = 1'b1;
        redirect(32'h40);
        tests++; if (bus.id_valid !== 1'b0) begin fails++; $display("FAIL rc_pop_flush: got id_valid %b want 0", bus.id_valid); end
        tick(10);
        tests++; if (pop_pc.size() < 1 || pop_pc[0] !== 32'h40) begin fails++; $display("FAIL rc_pop_next: got %h want 40", pop_pc[0]); end
    endtask

    task automatic test_midrun_reset();
        bit found = 0;
        start(4, 1'b0);
        for (int i = 0; i < 30 && !found; i++) begin
            tick(1);
            if (reqs.size() == 2) found = 1;
        end
        tests++; if (!found || bus.id_valid !== 1'b1) begin fails++; $display("FAIL mr_pre: got found %b id_valid %b want 1 1", found, bus.id_valid); end
        rstn = 1'b0;
        tick(1);
        tests++; if (bus.id_valid !== 1'b0 || bus.imem_req_valid !== 1'b0 || bus.id_pc !== 32'h0) begin fails++; $display("FAIL mr_during: got id_valid %b req_valid %b pc %h want 0 0 0", bus.id_valid, bus.imem_req_valid, bus.id_pc); end
        rstn = 1'b1;
        clear_logs();
        bus.id_ready = 1'b1;
        tick(20);
        tests++; if (reqs.size() < 2 || reqs[0] !== 32'h0 || reqs[1] !== 32'h4) begin fails++; $display("FAIL mr_restart_fetch: got %h %h want 0 4", reqs[0], reqs[1]); end
        tests++; if (pop_pc.size() < 1 || pop_pc[0] !== 32'h0 || pop_instr[0] !== 32'h13) begin fails++; $display("FAIL mr_restart_pop: got pc %h instr %h want 0 13", pop_pc[0], pop_instr[0]); end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_req_stall();
        test_redirect_wait();
        test_redirect_corners();
        test_midrun_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
